// File: rtl/tmr_simplex_voter.sv
// Triple-modular-redundancy voter with lane retirement: TMR -> DUPLEX -> FAIL.
// Bitwise majority is registered to vote_out; persistent miscompares retire lanes.
module tmr_simplex_voter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned THRESH = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   input  logic             err_ctrl_a,
   input  logic             err_ctrl_b,
   input  logic             err_ctrl_c,
   output logic [WIDTH-1:0] vote_out,
   output logic             tmr_error,
   output logic [2:0]       lane_fail,
   output logic [1:0]       mode,
   output logic             fatal,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned CW = ($clog2(THRESH + 1) < 1) ? 1 : $clog2(THRESH + 1);
   localparam logic [CW-1:0] TH = CW'(THRESH);

   typedef enum logic [1:0] {
      MODE_TMR    = 2'b00,
      MODE_DUPLEX = 2'b01,
      MODE_FAIL   = 2'b10
   } mode_t;

   mode_t            r_mode,      w_mode_nxt;
   logic [CW-1:0]    r_cnt_a,     w_cnt_a_nxt;
   logic [CW-1:0]    r_cnt_b,     w_cnt_b_nxt;
   logic [CW-1:0]    r_cnt_c,     w_cnt_c_nxt;
   logic [CW-1:0]    r_cnt_d,     w_cnt_d_nxt;
   logic [2:0]       r_lane_fail, w_lane_fail_nxt;
   logic [WIDTH-1:0] r_vote,      w_vote_nxt;
   logic             r_tmr_error, w_tmr_error_nxt;
   logic [CNT_W-1:0] r_err_count, w_err_count_nxt;

   logic [WIDTH-1:0] w_e_a, w_e_b, w_e_c;
   logic [WIDTH-1:0] w_maj;
   logic [WIDTH-1:0] w_e_p, w_e_q;
   logic             w_mis_a, w_mis_b, w_mis_c, w_mis_d;
   logic [CNT_W-1:0] w_err_inc;
   logic [CW-1:0]    w_step_a, w_step_b, w_step_c, w_step_d;
   logic [2:0]       w_reach;

   // Consecutive-miscompare counter: clears on a match, saturates at THRESH.
   function automatic logic [CW-1:0] cnt_step(input logic mis, input logic [CW-1:0] cnt);
      if (!mis)
         return '0;
      return (cnt >= TH) ? cnt : cnt + CW'(1);
   endfunction

   assign w_e_a = err_ctrl_a ? ~in_a : in_a;
   assign w_e_b = err_ctrl_b ? ~in_b : in_b;
   assign w_e_c = err_ctrl_c ? ~in_c : in_c;

   assign w_maj   = (w_e_a & w_e_b) | (w_e_a & w_e_c) | (w_e_b & w_e_c);
   assign w_mis_a = (w_e_a != w_maj);
   assign w_mis_b = (w_e_b != w_maj);
   assign w_mis_c = (w_e_c != w_maj);

   // Duplex pair: p is the lower-index surviving lane and drives the output.
   always_comb begin
      w_e_p = w_e_a;
      w_e_q = w_e_b;
      case (r_lane_fail)
         3'b001: begin
            w_e_p = w_e_b;
            w_e_q = w_e_c;
         end
         3'b010: w_e_q = w_e_c;
         default: begin
         end
      endcase
   end

   assign w_mis_d   = (w_e_p != w_e_q);
   assign w_err_inc = (r_err_count == '1) ? r_err_count : r_err_count + CNT_W'(1);

   assign w_step_a = cnt_step(w_mis_a, r_cnt_a);
   assign w_step_b = cnt_step(w_mis_b, r_cnt_b);
   assign w_step_c = cnt_step(w_mis_c, r_cnt_c);
   assign w_step_d = cnt_step(w_mis_d, r_cnt_d);
   assign w_reach  = {w_step_c == TH, w_step_b == TH, w_step_a == TH};

   always_comb begin
      w_mode_nxt      = r_mode;
      w_cnt_a_nxt     = r_cnt_a;
      w_cnt_b_nxt     = r_cnt_b;
      w_cnt_c_nxt     = r_cnt_c;
      w_cnt_d_nxt     = r_cnt_d;
      w_lane_fail_nxt = r_lane_fail;
      w_vote_nxt      = r_vote;
      w_tmr_error_nxt = r_tmr_error;
      w_err_count_nxt = r_err_count;

      if (clr) begin
         w_mode_nxt      = MODE_TMR;
         w_cnt_a_nxt     = '0;
         w_cnt_b_nxt     = '0;
         w_cnt_c_nxt     = '0;
         w_cnt_d_nxt     = '0;
         w_lane_fail_nxt = '0;
         w_vote_nxt      = w_maj;
         w_tmr_error_nxt = 1'b0;
         w_err_count_nxt = '0;
      end else begin
         case (r_mode)
            MODE_TMR: begin
               w_vote_nxt      = w_maj;
               w_tmr_error_nxt = w_mis_a | w_mis_b | w_mis_c;
               if (w_mis_a | w_mis_b | w_mis_c)
                  w_err_count_nxt = w_err_inc;
               w_cnt_a_nxt = w_step_a;
               w_cnt_b_nxt = w_step_b;
               w_cnt_c_nxt = w_step_c;
               case (w_reach)
                  3'b000: begin
                  end
                  3'b001, 3'b010, 3'b100: begin
                     w_lane_fail_nxt = w_reach;
                     w_mode_nxt      = MODE_DUPLEX;
                     w_cnt_a_nxt     = '0;
                     w_cnt_b_nxt     = '0;
                     w_cnt_c_nxt     = '0;
                     w_cnt_d_nxt     = '0;
                  end
                  default: w_mode_nxt = MODE_FAIL;
               endcase
            end
            MODE_DUPLEX: begin
               w_vote_nxt      = w_e_p;
               w_tmr_error_nxt = w_mis_d;
               if (w_mis_d)
                  w_err_count_nxt = w_err_inc;
               w_cnt_d_nxt = w_step_d;
               if (w_step_d == TH)
                  w_mode_nxt = MODE_FAIL;
            end
            default: begin
               w_mode_nxt      = MODE_FAIL;
               w_tmr_error_nxt = 1'b1;
               w_err_count_nxt = w_err_inc;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode      <= MODE_TMR;
         r_cnt_a     <= '0;
         r_cnt_b     <= '0;
         r_cnt_c     <= '0;
         r_cnt_d     <= '0;
         r_lane_fail <= '0;
         r_vote      <= '0;
         r_tmr_error <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_mode      <= w_mode_nxt;
         r_cnt_a     <= w_cnt_a_nxt;
         r_cnt_b     <= w_cnt_b_nxt;
         r_cnt_c     <= w_cnt_c_nxt;
         r_cnt_d     <= w_cnt_d_nxt;
         r_lane_fail <= w_lane_fail_nxt;
         r_vote      <= w_vote_nxt;
         r_tmr_error <= w_tmr_error_nxt;
         r_err_count <= w_err_count_nxt;
      end
   end

   assign vote_out  = r_vote;
   assign tmr_error = r_tmr_error;
   assign lane_fail = r_lane_fail;
   assign mode      = r_mode;
   assign fatal     = (r_mode == MODE_FAIL);
   assign err_count = r_err_count;

endmodule

// File: tb/tb_tmr_simplex_voter.sv
// Bench for tmr_simplex_voter: three builds (THRESH=3/CNT_W=16, THRESH=3/CNT_W=4, THRESH=1)
// share stimulus and are checked every cycle against a lane-level behavioural model.
module tb_tmr_simplex_voter;

   logic       clk;
   logic       rst;
   logic       clr;
   logic [7:0] in_a, in_b, in_c;
   logic       xa, xb, xc;

   logic [7:0]  v0, v1, v2;
   logic        te0, te1, te2;
   logic [2:0]  lf0, lf1, lf2;
   logic [1:0]  md0, md1, md2;
   logic        fa0, fa1, fa2;
   logic [15:0] ec0, ec2;
   logic [3:0]  ec1;

   tmr_simplex_voter #(.WIDTH(8), .THRESH(3), .CNT_W(16)) u_d0 (
      .clk(clk), .rst(rst), .clr(clr), .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .err_ctrl_a(xa), .err_ctrl_b(xb), .err_ctrl_c(xc),
      .vote_out(v0), .tmr_error(te0), .lane_fail(lf0), .mode(md0), .fatal(fa0), .err_count(ec0));

   tmr_simplex_voter #(.WIDTH(8), .THRESH(3), .CNT_W(4)) u_d1 (
      .clk(clk), .rst(rst), .clr(clr), .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .err_ctrl_a(xa), .err_ctrl_b(xb), .err_ctrl_c(xc),
      .vote_out(v1), .tmr_error(te1), .lane_fail(lf1), .mode(md1), .fatal(fa1), .err_count(ec1));

   tmr_simplex_voter #(.WIDTH(8), .THRESH(1), .CNT_W(16)) u_d2 (
      .clk(clk), .rst(rst), .clr(clr), .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .err_ctrl_a(xa), .err_ctrl_b(xb), .err_ctrl_c(xc),
      .vote_out(v2), .tmr_error(te2), .lane_fail(lf2), .mode(md2), .fatal(fa2), .err_count(ec2));

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   int         th[3]    = '{3, 3, 1};
   int         ecmax[3] = '{65535, 15, 65535};
   int         m_mode[3];
   int         m_cnt[3][3];
   int         m_cntd[3];
   logic [2:0] m_lf[3];
   logic [7:0] m_vote[3];
   logic       m_terr[3];
   int         m_ec[3];

   logic [7:0] e[3];
   logic [7:0] maj;
   logic [7:0] rv[3];
   logic       rx[3];
   logic [7:0] base;
   int         flane;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset(input int d);
      m_mode[d] = 0;
      m_cntd[d] = 0;
      for (int x = 0; x < 3; x++) m_cnt[d][x] = 0;
      m_lf[d]   = 3'b000;
      m_vote[d] = 8'h00;
      m_terr[d] = 1'b0;
      m_ec[d]   = 0;
   endtask

   task automatic model_bump(input int d);
      if (m_ec[d] < ecmax[d]) m_ec[d]++;
   endtask

   // One clock of the voter rules for build d, using the effective lanes e[] and majority maj.
   task automatic model_step(input int d);
      int  reached;
      int  miss;
      int  p;
      int  q;
      int  fl;
      if (clr) begin
         model_reset(d);
         m_vote[d] = maj;
         return;
      end
      if (m_mode[d] == 0) begin
         reached = 0;
         miss    = 0;
         fl      = 0;
         for (int x = 0; x < 3; x++) begin
            if (e[x] != maj) begin
               miss++;
               m_cnt[d][x] = (m_cnt[d][x] + 1 > th[d]) ? th[d] : m_cnt[d][x] + 1;
               if (m_cnt[d][x] == th[d]) begin
                  reached++;
                  fl = x;
               end
            end else begin
               m_cnt[d][x] = 0;
            end
         end
         m_vote[d] = maj;
         m_terr[d] = (miss > 0);
         if (miss > 0) model_bump(d);
         if (reached == 1) begin
            m_lf[d]   = 3'b001 << fl;
            m_mode[d] = 1;
            m_cntd[d] = 0;
            for (int x = 0; x < 3; x++) m_cnt[d][x] = 0;
         end else if (reached >= 2) begin
            m_mode[d] = 2;
         end
      end else if (m_mode[d] == 1) begin
         p = -1;
         q = -1;
         for (int x = 0; x < 3; x++)
            if (!m_lf[d][x]) begin
               if (p < 0) p = x;
               else if (q < 0) q = x;
            end
         m_vote[d] = e[p];
         m_terr[d] = (e[p] != e[q]);
         if (e[p] != e[q]) begin
            model_bump(d);
            m_cntd[d] = (m_cntd[d] + 1 > th[d]) ? th[d] : m_cntd[d] + 1;
            if (m_cntd[d] == th[d]) m_mode[d] = 2;
         end else begin
            m_cntd[d] = 0;
         end
      end else begin
         m_terr[d] = 1'b1;
         model_bump(d);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 3; d++) model_reset(d);
      end else begin
         e[0] = xa ? ~in_a : in_a;
         e[1] = xb ? ~in_b : in_b;
         e[2] = xc ? ~in_c : in_c;
         for (int i = 0; i < 8; i++)
            maj[i] = (int'(e[0][i]) + int'(e[1][i]) + int'(e[2][i])) >= 2;
         for (int d = 0; d < 3; d++) model_step(d);
      end
   end

   task automatic cmp(input int d, input logic [7:0] v, input logic te, input logic [2:0] lf,
                      input logic [1:0] md, input logic fa, input logic [15:0] ec);
      chk($sformatf("d%0d vote_out", d), 32'(v), 32'(m_vote[d]));
      chk($sformatf("d%0d tmr_error", d), 32'(te), 32'(m_terr[d]));
      chk($sformatf("d%0d lane_fail", d), 32'(lf), 32'(m_lf[d]));
      chk($sformatf("d%0d mode", d), 32'(md), 32'(m_mode[d]));
      chk($sformatf("d%0d fatal", d), 32'(fa), 32'(m_mode[d] == 2));
      chk($sformatf("d%0d err_count", d), 32'(ec), 32'(m_ec[d]));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, v0, te0, lf0, md0, fa0, ec0);
         cmp(1, v1, te1, lf1, md1, fa1, {12'h000, ec1});
         cmp(2, v2, te2, lf2, md2, fa2, ec2);
      end
   end

   task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic ea, input logic eb, input logic ecc, input logic cl);
      in_a = a; in_b = b; in_c = c;
      xa = ea; xb = eb; xc = ecc;
      clr = cl;
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0;
      in_a = '0; in_b = '0; in_c = '0;
      xa = 1'b0; xb = 1'b0; xc = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset vote_out", 32'(v0), 32'h00);
      chk("reset mode", 32'(md0), 32'h0);
      chk("reset lane_fail", 32'(lf0), 32'h0);
      chk("reset err_count", 32'(ec0), 32'h0);
      chk("reset fatal", 32'(fa0), 32'h0);
      rst = 1'b1;

      step(8'hA5, 8'hA5, 8'hA5, 0, 0, 0, 0);
      chk("basic vote_out", 32'(v0), 32'hA5);
      chk("basic tmr_error", 32'(te0), 32'h0);
      chk("basic mode", 32'(md0), 32'h0);

      step(8'hA5, 8'hA5, 8'hA5, 0, 1, 0, 0);
      chk("transient1 tmr_error", 32'(te0), 32'h1);
      chk("transient1 vote_out", 32'(v0), 32'hA5);
      chk("thresh1 lane_fail", 32'(lf2), 32'h2);
      chk("thresh1 mode", 32'(md2), 32'h1);
      step(8'hA5, 8'hA5, 8'hA5, 0, 1, 0, 0);
      chk("transient2 tmr_error", 32'(te0), 32'h1);
      step(8'hA5, 8'hA5, 8'hA5, 0, 0, 0, 0);
      chk("transient end tmr_error", 32'(te0), 32'h0);
      chk("transient err_count", 32'(ec0), 32'd2);
      chk("transient mode", 32'(md0), 32'h0);
      chk("transient lane_fail", 32'(lf0), 32'h0);

      repeat (3) step(8'hA5, 8'hA5, 8'hA5, 0, 1, 0, 0);
      chk("retire lane_fail", 32'(lf0), 32'h2);
      chk("retire mode", 32'(md0), 32'h1);
      chk("retire err_count", 32'(ec0), 32'd5);
      step(8'h3C, 8'hA5, 8'h3C, 0, 1, 0, 0);
      chk("duplex vote_out", 32'(v0), 32'h3C);
      chk("duplex tmr_error", 32'(te0), 32'h0);

      // Asynchronous reset pulse between clock edges while in DUPLEX.
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async rst vote_out", 32'(v0), 32'h00);
      chk("async rst mode", 32'(md0), 32'h0);
      chk("async rst lane_fail", 32'(lf0), 32'h0);
      chk("async rst err_count", 32'(ec0), 32'h0);
      chk("async rst tmr_error", 32'(te0), 32'h0);
      #1 rst = 1'b1;
      @(negedge clk);
      #1;

      repeat (3) step(8'hA5, 8'hA5, 8'hA5, 0, 1, 0, 0);
      chk("re-retire mode", 32'(md0), 32'h1);
      for (int k = 0; k < 3; k++) begin
         step(8'hFF, 8'h00, 8'h00, 0, 0, 0, 0);
         chk("duplex fatal vote_out", 32'(v0), 32'hFF);
      end
      chk("duplex fatal mode", 32'(md0), 32'h2);
      chk("duplex fatal fatal", 32'(fa0), 32'h1);
      chk("duplex fatal err_count", 32'(ec0), 32'd6);
      step(8'h11, 8'h00, 8'h00, 0, 0, 0, 0);
      chk("fail hold vote_out", 32'(v0), 32'hFF);
      chk("fail err_count", 32'(ec0), 32'd7);

      step(8'h5A, 8'h5A, 8'h5A, 0, 0, 0, 1);
      chk("clr mode", 32'(md0), 32'h0);
      chk("clr lane_fail", 32'(lf0), 32'h0);
      chk("clr err_count", 32'(ec0), 32'h0);
      chk("clr fatal", 32'(fa0), 32'h0);
      chk("clr vote_out", 32'(v0), 32'h5A);

      for (int k = 0; k < 3; k++) begin
         step(8'hA4, 8'hA5, 8'h25, 0, 0, 0, 0);
         chk("simul vote_out", 32'(v0), 32'hA5);
      end
      chk("simul mode", 32'(md0), 32'h2);
      chk("simul fatal", 32'(fa0), 32'h1);
      chk("simul lane_fail", 32'(lf0), 32'h0);
      repeat (20) step(8'hA4, 8'hA5, 8'h25, 0, 0, 0, 0);
      chk("sat err_count cnt4", 32'(ec1), 32'hF);
      chk("nosat err_count cnt16", 32'(ec0), 32'd23);
      step(8'h00, 8'h00, 8'h00, 0, 0, 0, 1);

      flane = 3;
      for (int n = 0; n < 2500; n++) begin
         if (n % 16 == 0) flane = int'($urandom_range(0, 3));
         base = 8'($urandom);
         for (int l = 0; l < 3; l++) begin
            rv[l] = base;
            if ($urandom_range(0, 9) == 0) rv[l] = rv[l] ^ (8'd1 << $urandom_range(0, 7));
            rx[l] = (l == flane) && ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 199) == 0) rst = 1'b0;
         step(rv[0], rv[1], rv[2], rx[0], rx[1], rx[2], $urandom_range(0, 29) == 0);
         rst = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
